gate_seq_ctrl: RTL and testbench

Sequencing controller for the gate-enable chain. Brings N gates up one at a time, lowest index first, and takes them down in reverse order. After each gate step it waits for that gate's sync feedback, then holds a programmable dwell before the next step. It detects sync timeouts and loss of sync while running, and forces all gates off on any fault. Sits between the register/AXI config layer and the gate datapath; gate_en_o drives the gates and gate_sync_i returns their state.

---
 rtl/gate_seq_pkg.sv | 22 ++
 rtl/gate_seq_ctrl_timer.sv | 44 ++++
 rtl/gate_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_gate_seq_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and defaults for the gate sequencing controller.
//   state_e     : 4-bit FSM state encoding, also exported on state_o
//   NGateDef    : default number of gates in the chain
//   CntWDef     : default width of the dwell/timeout counter
package gate_seq_pkg;

  localparam int unsigned NGateDef = 5;
  localparam int unsigned CntWDef  = 32;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StUpEn    = 4'd1,
    StUpSync  = 4'd2,
    StUpDwell = 4'd3,
    StRun     = 4'd4,
    StDnDis   = 4'd5,
    StDnSync  = 4'd6,
    StDnDwell = 4'd7,
    StFault   = 4'd8
  } state_e;

endpackage

// File: rtl/gate_seq_ctrl_timer.sv
// Saturating up-counter shared by the dwell and sync-timeout phases.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   clr_i           : synchronous clear (wins over inc_i)
//   inc_i           : count up by one, holding at all-ones
//   shift_i         : dwell length to compare against
//   timeout_i       : timeout length to compare against
//   eq_shift_o      : counter equals shift_i
//   eq_timeout_o    : counter equals timeout_i
module gate_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] shift_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             eq_shift_o,
  output logic             eq_timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_shift_o   = (cnt_q == shift_i);
  assign eq_timeout_o = (cnt_q == timeout_i);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Gate-enable chain sequencer: ramps gates up lowest-first, down highest-first,
// waiting for per-gate sync feedback plus a dwell after each step. Any sync
// timeout or loss of sync in RUN forces every gate off and parks in FAULT.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   start_i/stop_i  : one-cycle ramp-up / ramp-down requests
//   clear_i         : leave FAULT
//   shift_i         : dwell cycles, latched on start
//   timeout_i       : sync wait limit (0 = none), latched on start
//   gate_sync_i     : per-gate sync feedback
//   gate_en_o       : registered gate enables
//   busy_o, run_o, done_o, fault_o, state_o : status
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int unsigned N_GATE = NGateDef,
  parameter int unsigned CNT_W  = CntWDef
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
  input  logic [CNT_W-1:0]  shift_i,
  input  logic [CNT_W-1:0]  timeout_i,
  input  logic [N_GATE-1:0] gate_sync_i,
  output logic [N_GATE-1:0] gate_en_o,
  output logic              busy_o,
  output logic              run_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [3:0]        state_o
);

  localparam int unsigned IdxW = $clog2(N_GATE);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_GATE - 1);

  state_e            state_q, state_d;
  logic [N_GATE-1:0] gate_en_q, gate_en_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic              done_q, done_d;

  logic cnt_clr, cnt_inc;
  logic eq_shift, eq_timeout;
  logic sync_ok, to_hit;

  gate_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (cnt_clr),
    .inc_i        (cnt_inc),
    .shift_i      (shift_q),
    .timeout_i    (timeout_q),
    .eq_shift_o   (eq_shift),
    .eq_timeout_o (eq_timeout)
  );

  assign sync_ok = (gate_sync_i == gate_en_q);
  assign to_hit  = (timeout_q != '0) && eq_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      gate_en_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  // Priority inside each state: fault > stop > normal progress.
  always_comb begin
    state_d   = state_q;
    gate_en_d = gate_en_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_d   = StUpEn;
          idx_d     = '0;
          shift_d   = shift_i;
          timeout_d = timeout_i;
        end
      end
      StUpEn: begin
        if (stop_i) begin
          state_d = StDnDis;
        end else begin
          gate_en_d[idx_q] = 1'b1;
          cnt_clr          = 1'b1;
          state_d          = StUpSync;
        end
      end
      StUpSync: begin
        if (!sync_ok && to_hit) begin
          state_d = StFault;
        end else if (stop_i) begin
          state_d = StDnDis;
        end else if (sync_ok) begin
          cnt_clr = 1'b1;
          state_d = StUpDwell;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StUpDwell: begin
        if (stop_i) begin
          state_d = StDnDis;
        end else if (eq_shift) begin
          if (idx_q == IdxLast) begin
            state_d = StRun;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StUpEn;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StRun: begin
        if (!sync_ok) begin
          state_d = StFault;
        end else if (stop_i) begin
          idx_d   = IdxLast;
          state_d = StDnDis;
        end
      end
      StDnDis: begin
        // Bit may already be clear after an aborted ramp-up; harmless.
        gate_en_d[idx_q] = 1'b0;
        cnt_clr          = 1'b1;
        state_d          = StDnSync;
      end
      StDnSync: begin
        if (!sync_ok && to_hit) begin
          state_d = StFault;
        end else if (sync_ok) begin
          cnt_clr = 1'b1;
          state_d = StDnDwell;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StDnDwell: begin
        if (eq_shift) begin
          if (idx_q == '0) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StDnDis;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      StFault: begin
        if (clear_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StFault;
      end
    endcase
    if (state_d == StFault) begin
      gate_en_d = '0;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    unique case (state_q)
      StUpEn, StUpSync, StUpDwell, StDnDis, StDnSync, StDnDwell: busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
    run_o     = (state_q == StRun);
    fault_o   = (state_q == StFault);
    done_o    = done_q;
    gate_en_o = gate_en_q;
    state_o   = state_q;
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
module tb_gate_seq_ctrl;

  localparam int N = 5;
  localparam int W = 32;

  typedef struct {
    int         cyc;
    logic [4:0] gate;
    logic       busy;
    logic       run;
    logic       done;
    logic       fault;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [W-1:0] shift = '0, timeout = '0;
  logic [N-1:0] gate_sync, gate_en, sync_force = '0;
  logic         tie = 1'b1;
  logic         busy, run, done, fault;
  logic [3:0]   state;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  assign gate_sync = tie ? gate_en : sync_force;

  gate_seq_ctrl #(
    .N_GATE (N),
    .CNT_W  (W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .clear_i     (clear),
    .shift_i     (shift),
    .timeout_i   (timeout),
    .gate_sync_i (gate_sync),
    .gate_en_o   (gate_en),
    .busy_o      (busy),
    .run_o       (run),
    .done_o      (done),
    .fault_o     (fault),
    .state_o     (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [4:0] g, input logic b, input logic r,
                      input logic d, input logic f);
    ev_t e;
    e.cyc = c; e.gate = g; e.busy = b; e.run = r; e.done = d; e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Monitor: every change of the observable tuple is one output event.
  logic [8:0] prev = '0;
  always @(negedge clk) begin
    logic [8:0] cur, expv;
    ev_t e;
    if (mon_en) begin
      cur = {gate_en, busy, run, done, fault};
      if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: cyc %0d got %b, expected none", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          expv = {e.gate, e.busy, e.run, e.done, e.fault};
          if (e.cyc == cyc && expv === cur) n_pass++;
          else $display("FAIL event: got cyc %0d %b, expected cyc %0d %b", cyc, cur, e.cyc,
                        expv);
        end
        prev = cur;
      end
    end
  end

  // Full ramp-up with shift=2 and sync tied to gate_en.
  task automatic ramp_up();
    int k;
    @(negedge clk);
    shift = 2; timeout = 0; start = 1'b1;
    k = cyc + 1;
    push(k,      5'b00000, 1, 0, 0, 0);
    push(k + 1,  5'b00001, 1, 0, 0, 0);
    push(k + 6,  5'b00011, 1, 0, 0, 0);
    push(k + 11, 5'b00111, 1, 0, 0, 0);
    push(k + 16, 5'b01111, 1, 0, 0, 0);
    push(k + 21, 5'b11111, 1, 0, 0, 0);
    push(k + 25, 5'b11111, 0, 1, 1, 0);
    push(k + 26, 5'b11111, 0, 1, 0, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("run_state", state, 4);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    push(cyc + 1, 5'b00000, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("clear_idle", state, 0);
  endtask

  initial begin
    int k, s;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_gate", gate_en, 0);
    check("rst_state", state, 0);
    check("rst_flags", {busy, run, done, fault}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp up, then full ramp down from RUN
    ramp_up();
    @(negedge clk);
    stop = 1'b1;
    s = cyc + 1;
    push(s,      5'b11111, 1, 0, 0, 0);
    push(s + 1,  5'b01111, 1, 0, 0, 0);
    push(s + 6,  5'b00111, 1, 0, 0, 0);
    push(s + 11, 5'b00011, 1, 0, 0, 0);
    push(s + 16, 5'b00001, 1, 0, 0, 0);
    push(s + 21, 5'b00000, 1, 0, 0, 0);
    push(s + 25, 5'b00000, 0, 0, 0, 0);
    @(negedge clk);
    stop = 1'b0;
    repeat (30) @(negedge clk);
    check("down_idle", state, 0);

    // Sync timeout; timeout_i changed after start must be ignored
    tie = 1'b0; sync_force = '0;
    @(negedge clk);
    shift = 2; timeout = 4; start = 1'b1;
    k = cyc + 1;
    push(k,     5'b00000, 1, 0, 0, 0);
    push(k + 1, 5'b00001, 1, 0, 0, 0);
    push(k + 6, 5'b00000, 0, 0, 0, 1);
    @(negedge clk);
    start = 1'b0; timeout = 0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_hold_state", state, 8);
    check("fault_hold_flag", fault, 1);
    tie = 1'b1;
    do_clear();

    // Loss of sync in RUN
    ramp_up();
    @(negedge clk);
    tie = 1'b0; sync_force = 5'b11011;
    push(cyc + 1, 5'b00000, 0, 0, 0, 1);
    @(negedge clk);
    tie = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_fault", state, 8);
    do_clear();

    // Abort ramp-up during UP_DWELL at idx=2
    @(negedge clk);
    shift = 2; timeout = 0; start = 1'b1;
    k = cyc + 1;
    push(k,      5'b00000, 1, 0, 0, 0);
    push(k + 1,  5'b00001, 1, 0, 0, 0);
    push(k + 6,  5'b00011, 1, 0, 0, 0);
    push(k + 11, 5'b00111, 1, 0, 0, 0);
    push(k + 14, 5'b00011, 1, 0, 0, 0);
    push(k + 19, 5'b00001, 1, 0, 0, 0);
    push(k + 24, 5'b00000, 1, 0, 0, 0);
    push(k + 28, 5'b00000, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 12) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_idle", state, 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("start_stop_idle", state, 0);
    check("start_stop_busy", busy, 0);

    // Asynchronous reset mid-ramp
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    push(k,     5'b00000, 1, 0, 0, 0);
    push(k + 1, 5'b00001, 1, 0, 0, 0);
    push(k + 6, 5'b00011, 1, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 8) @(negedge clk);
    push(cyc + 1, 5'b00000, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_gate", gate_en, 0);
    check("async_rst_state", state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("events_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
